lnvd_band_norm: RTL and testbench
=================================

# lnvd_band_norm

Parametrised multi-channel sample normaliser for the LNVD signal chain, replacing the fixed 4 × 12-bit pass-through stage between ADC capture and downstream processing. Each frame of CH unsigned samples is processed through one shared datapath, one channel per cycle. Per channel, the block removes DC with an exponential moving average and applies a power-of-two automatic gain derived from a decaying peak tracker. Frames move on valid/ready handshakes on both sides.

## Interface
- W, 12: sample width in bits. Input is unsigned offset-binary; output is two's-complement signed.
- CH, 4: channel count, minimum 1.
- ALPHA_SHIFT, 4: EMA time constant, where alpha = 2^-ALPHA_SHIFT.
- DECAY_SHIFT, 4: per-frame peak decay, where pk -= pk >> DECAY_SHIFT.
- MAX_SHIFT, 4: maximum left-shift gain.
- GW, $clog2(MAX_SHIFT+1): gain field width.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame. It is high exactly when the FSM is in IDLE.
- in_data  in  CH*W  packed samples. Channel c occupies bits [c*W +: W].
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_data  out  CH*W  packed signed normalised samples.
- out_gain  out  CH*GW  shift applied to each channel.

## Operation
- FSM states are IDLE, PROC and HOLD. Transitions:
  - IDLE → PROC on in_valid && in_ready. The full in_data bus is captured and the channel counter is cleared.
  - PROC processes channel idx and increments idx. It moves to HOLD after idx = CH-1.
  - HOLD → IDLE on out_valid && out_ready.
- Per-channel state lives in CH-entry register arrays:
  - acc[c], width W+ALPHA_SHIFT, resets to 2^(W-1) << ALPHA_SHIFT (midscale).
  - pk[c], width W, resets to 0.
- Per-channel datapath for sample x:
  - mean = acc >> ALPHA_SHIFT.
  - ac = x - mean, signed W+1, saturated to signed W.
  - pk_new = max(|ac|, pk - (pk >> DECAY_SHIFT)).
  - g = the largest s ≤ MAX_SHIFT such that (pk_new << s) ≤ 2^(W-1)-1. If no s satisfies this, g = 0. If pk_new = 0, g = MAX_SHIFT.
  - out = sat_W(ac <<< g).
  - State updates: acc += x - mean, and pk = pk_new.
- out_data and out_gain lanes are written during PROC. They are held stable throughout HOLD.
- in_data is ignored outside accepting cycles. A transfer occurs only on a cycle where valid && ready.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1 once rst_n is high.
  - out_valid = 0.
  - out_data = 0.
  - out_gain = 0.
  - acc and pk arrays take their reset values.
- Latency: if a frame is accepted at edge T, out_valid rises after edge T+CH.
- Minimum frame period is CH+2 cycles, which is 6 cycles at CH = 4. This is well inside the 250 kHz sample rate.
- Backpressure: while HOLD persists, out_data and out_gain are stable and in_ready = 0.
- If out_ready is already high when out_valid rises, the output transfer completes in that cycle. in_ready returns high on the next cycle.
- Reset asserted mid-PROC or mid-HOLD: the in-flight frame is discarded, all state returns to its reset values, and no partial frame is emitted.
- Wrap-around: acc cannot overflow, because it stays within [0, (2^W-1) << ALPHA_SHIFT].

## Configuration
- LNVD_NORM_AGC_EN defined: gain stage active, as described above.
- LNVD_NORM_AGC_EN undefined: the peak tracker and gain logic are removed. out = ac (DC-removed and saturated), and out_gain is constant 0. Latency and handshake are unchanged.

## Structure
- Package lnvd_pkg holds:
  - the FSM state enum (IDLE, PROC, HOLD);
  - the signed saturation function sat_w;
  - reset-constant helpers for the acc midscale value.
- Sub-module lnvd_norm_lane: the combinational single-channel datapath. Inputs are x, acc, pk. Outputs are out, g, acc_next, pk_next.

## Test plan
Bench parameters: W=12, CH=4, ALPHA_SHIFT=4, DECAY_SHIFT=4, MAX_SHIFT=4.
- Reset: all outputs are 0 during reset, and in_ready = 1 on the first cycle after rst_n rises.
- Constant 2048 on every channel → out_data all 0, out_gain all 4.
- First frame after reset with ch0 = 2148 → ch0 out = 1600 (100 << 4), gain 4.
- First frame after reset with ch1 = 4095 → out = 2047, gain 0. A second frame of 4095 sees mean = 2175.
- out_ready held low for 10 cycles → out_data and out_gain unchanged, in_ready stays 0, and in_valid pulses are not accepted.
- rst_n pulsed low two cycles into PROC → out_valid never rises for that frame. The next frame behaves as if it were the first after reset.

Source files
------------

// File: rtl/lnvd_pkg.sv
// Shared types and helpers for the LNVD band normaliser.
package lnvd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StProc = 2'd1,
    StHold = 2'd2
  } state_e;

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] v,
                                               input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Midscale mean (2^(w-1)) pre-scaled into the EMA accumulator domain.
  function automatic logic [31:0] acc_mid(input int unsigned w, input int unsigned alpha_shift);
    return 32'd1 << (w - 1 + alpha_shift);
  endfunction

endpackage

// File: rtl/lnvd_norm_lane.sv
// Combinational single-channel datapath: EMA DC removal plus optional power-of-two AGC.
// Gain stage present only when LNVD_NORM_AGC_EN is defined.
module lnvd_norm_lane
  import lnvd_pkg::*;
#(
  parameter int unsigned W           = 12,
  parameter int unsigned ALPHA_SHIFT = 4,
  parameter int unsigned DECAY_SHIFT = 4,
  parameter int unsigned MAX_SHIFT   = 4,
  parameter int unsigned GW          = $clog2(MAX_SHIFT + 1)
) (
  input  logic [W-1:0]             x,
  input  logic [W+ALPHA_SHIFT-1:0] acc,
  input  logic [W-1:0]             pk,
  output logic [W-1:0]             out,
  output logic [GW-1:0]            g,
  output logic [W+ALPHA_SHIFT-1:0] acc_next,
  output logic [W-1:0]             pk_next
);

  localparam int unsigned AccW = W + ALPHA_SHIFT;

  logic [W-1:0]        mean;
  logic [W:0]          diff;
  logic signed [31:0]  ac_wide;
  logic signed [W-1:0] ac;

  always_comb begin
    mean     = acc[AccW-1:ALPHA_SHIFT];
    diff     = {1'b0, x} - {1'b0, mean};
    ac_wide  = sat_w({{(31 - W){diff[W]}}, diff}, W);
    ac       = ac_wide[W-1:0];
    acc_next = acc + AccW'(x) - AccW'(mean);
  end

`ifdef LNVD_NORM_AGC_EN
  localparam int unsigned ExtW = W + MAX_SHIFT;
  localparam logic [ExtW-1:0] Lim = ExtW'({(W - 1){1'b1}});

  logic [W-1:0]       mag;
  logic [W-1:0]       decayed;
  logic signed [31:0] shifted;
  logic signed [31:0] out_wide;
  logic               unused_bits;

  always_comb begin
    mag = unsigned'(ac);
    if (ac[W-1]) mag = ~mag + W'(1);
    decayed = pk - (pk >> DECAY_SHIFT);
    pk_next = (mag > decayed) ? mag : decayed;
    // Largest shift keeping the tracked peak within positive full scale; zero peak gives max.
    g = '0;
    for (int unsigned s = 0; s <= MAX_SHIFT; s++) begin
      if ((ExtW'(pk_next) << s) <= Lim) g = GW'(s);
    end
    shifted  = {{(32 - W){ac[W-1]}}, ac} <<< g;
    out_wide = sat_w(shifted, W);
    out      = out_wide[W-1:0];
  end

  assign unused_bits = ^{ac_wide[31:W], out_wide[31:W]};
`else
  logic unused_bits;

  assign pk_next     = '0;
  assign g           = '0;
  assign out         = ac;
  assign unused_bits = ^{pk, ac_wide[31:W], (DECAY_SHIFT != 0), (MAX_SHIFT != 0)};
`endif

endmodule

// File: rtl/lnvd_band_norm.sv
// Multi-channel sample normaliser: one shared lane processes a captured frame channel by channel.
// Define LNVD_NORM_AGC_EN to enable the peak-tracking automatic gain stage.
module lnvd_band_norm
  import lnvd_pkg::*;
#(
  parameter int unsigned W           = 12,
  parameter int unsigned CH          = 4,
  parameter int unsigned ALPHA_SHIFT = 4,
  parameter int unsigned DECAY_SHIFT = 4,
  parameter int unsigned MAX_SHIFT   = 4,
  parameter int unsigned GW          = $clog2(MAX_SHIFT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*W-1:0]  out_data,
  output logic [CH*GW-1:0] out_gain
);

  localparam int unsigned AccW = W + ALPHA_SHIFT;
  localparam int unsigned IdxW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [AccW-1:0] AccRst = AccW'(acc_mid(W, ALPHA_SHIFT));
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CH - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [CH*W-1:0] in_q;
  logic [AccW-1:0] acc_q [CH];
  logic [CH*W-1:0]  out_data_q;
  logic [CH*GW-1:0] out_gain_q;

  logic [W-1:0]    lane_x;
  logic [W-1:0]    lane_pk;
  logic [W-1:0]    lane_out;
  logic [W-1:0]    lane_pk_next;
  logic [AccW-1:0] lane_acc;
  logic [AccW-1:0] lane_acc_next;
  logic [GW-1:0]   lane_g;
  logic            accept;
  logic            last;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == LastIdx);
  assign out_data  = out_data_q;
  assign out_gain  = out_gain_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StProc;
      StProc:  if (last) state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q  <= in_data;
        idx_q <= '0;
      end else if (state_q == StProc) begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  assign lane_x   = in_q[int'(idx_q) * W +: W];
  assign lane_acc = acc_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) acc_q[c] <= AccRst;
    end else if (state_q == StProc) begin
      acc_q[idx_q] <= lane_acc_next;
    end
  end

`ifdef LNVD_NORM_AGC_EN
  logic [W-1:0] pk_q [CH];

  assign lane_pk = pk_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) pk_q[c] <= '0;
    end else if (state_q == StProc) begin
      pk_q[idx_q] <= lane_pk_next;
    end
  end
`else
  logic unused_pk_next;

  assign lane_pk        = '0;
  assign unused_pk_next = ^lane_pk_next;
`endif

  // Output lanes fill in during PROC and stay frozen through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_gain_q <= '0;
    end else if (state_q == StProc) begin
      out_data_q[int'(idx_q) * W +: W]   <= lane_out;
      out_gain_q[int'(idx_q) * GW +: GW] <= lane_g;
    end
  end

  lnvd_norm_lane #(
    .W          (W),
    .ALPHA_SHIFT(ALPHA_SHIFT),
    .DECAY_SHIFT(DECAY_SHIFT),
    .MAX_SHIFT  (MAX_SHIFT),
    .GW         (GW)
  ) u_lane (
    .x       (lane_x),
    .acc     (lane_acc),
    .pk      (lane_pk),
    .out     (lane_out),
    .g       (lane_g),
    .acc_next(lane_acc_next),
    .pk_next (lane_pk_next)
  );

endmodule

// File: tb/tb_lnvd_band_norm.sv
// Scoreboard bench for lnvd_band_norm: arithmetic reference model, randomized frames and backpressure.
module tb_lnvd_band_norm;

  localparam int W  = 12;
  localparam int CH = 4;
  localparam int GW = 3;
`ifdef LNVD_NORM_AGC_EN
  localparam bit Agc = 1'b1;
`else
  localparam bit Agc = 1'b0;
`endif

  typedef struct packed {
    logic [CH*W-1:0]  data;
    logic [CH*GW-1:0] gain;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CH*W-1:0]  out_data;
  logic [CH*GW-1:0] out_gain;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   or_mode = 0;
  int   acc_m[CH];
  int   pk_m[CH];

  always #5 clk = ~clk;

  lnvd_band_norm #(
    .W(W), .CH(CH), .ALPHA_SHIFT(4), .DECAY_SHIFT(4), .MAX_SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_gain(out_gain)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clamp(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      acc_m[c] = 2048 * 16;
      pk_m[c]  = 0;
    end
  endfunction

  function automatic exp_t model_frame(input logic [CH*W-1:0] d);
    exp_t e;
    int x, mean, ac, mag, dec, pkn, g, o;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      x    = int'(d[c*W +: W]);
      mean = acc_m[c] / 16;
      ac   = clamp(x - mean);
      acc_m[c] = acc_m[c] + x - mean;
      if (Agc) begin
        mag = (ac < 0) ? -ac : ac;
        dec = pk_m[c] - pk_m[c] / 16;
        pkn = (mag > dec) ? mag : dec;
        pk_m[c] = pkn;
        g = 0;
        for (int s = 4; s >= 0; s--) begin
          if (pkn * (1 << s) <= 2047) begin
            g = s;
            break;
          end
        end
        o = clamp(ac * (1 << g));
      end else begin
        g = 0;
        o = ac;
      end
      e.data[c*W +: W]   = o[W-1:0];
      e.gain[c*GW +: GW] = g[GW-1:0];
    end
    return e;
  endfunction

  // Expected response is queued at the moment a frame is accepted.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back(model_frame(in_data));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_while_out_valid", in_ready, 0);
      if (sb.size() == 0) begin
        check("unexpected_output", out_valid, 0);
      end else begin
        check("sb_data", out_data, sb[0].data);
        check("sb_gain", out_gain, sb[0].gain);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_gain", out_gain, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic send_frame(input logic [CH*W-1:0] d);
    int   n;
    logic acc;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("frame_accepted", acc, 1);
  endtask

  task automatic wait_out(output logic [CH*W-1:0] d, output logic [CH*GW-1:0] g);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", out_valid, 1);
    d = out_data;
    g = out_gain;
  endtask

  logic [CH*W-1:0]  d, d0, f, f2;
  logic [CH*GW-1:0] g, g0;
  int               n;

  initial begin
    model_reset();
    do_reset();

    // Midscale on every channel: no AC content, zero peak.
    send_frame({4{12'd2048}});
    wait_out(d, g);
    check("mid_data", d, 0);
    check("mid_gain", g, Agc ? 12'h924 : 12'h000);

    do_reset();
    f = {12'd2048, 12'd2048, 12'd4095, 12'd2148};
    send_frame(f);
    wait_out(d, g);
    check("ch0_out", d[11:0], Agc ? 1600 : 100);
    check("ch0_gain", g[2:0], Agc ? 4 : 0);
    check("ch1_out", d[23:12], 2047);
    check("ch1_gain", g[5:3], 0);
    send_frame(f);
    wait_out(d, g);
    check("ch1_second_out", d[23:12], 4095 - 2175);

    // Backpressure: output held, inputs refused.
    or_mode = 2;
    send_frame(48'({$urandom, $urandom}));
    wait_out(d0, g0);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 48'({$urandom, $urandom});
      @(negedge clk);
      check("hold_data", out_data, d0);
      check("hold_gain", out_gain, g0);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    or_mode = 0;

    // Reset two cycles into PROC discards the frame.
    send_frame(48'({$urandom, $urandom}));
    @(posedge clk);
    do_reset();
    repeat (8) begin
      @(negedge clk);
      check("no_partial_frame", out_valid, 0);
    end
    send_frame(f);
    wait_out(d, g);
    check("post_rst_ch0_out", d[11:0], Agc ? 1600 : 100);
    check("post_rst_ch1_out", d[23:12], 2047);

    // Randomized frames under random backpressure.
    or_mode = 1;
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 1) != 0) f2[c*W +: W] = 12'($urandom_range(0, 4095));
        else f2[c*W +: W] = 12'(2048 + $urandom_range(0, 64) - 32);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_frame(f2);
    end
    or_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
